// File: rtl/framebuffer_pwm.sv
// Double-buffered frame store with a three-stage PWM read pipeline.
// Host writes go to the back bank; buffer swaps happen only inside the driver's safe_flip window.
module framebuffer_pwm #(
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitdepth = 8,
    localparam int RW      = (rows > 1) ? $clog2(rows) : 1,
    localparam int CW      = (columns > 1) ? $clog2(columns) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RW-1:0]         row,
    input  logic [CW-1:0]         column,
    input  logic [bitdepth-1:0]   cycle,
    input  logic                  safe_flip,
    input  logic                  wr_en,
    input  logic [RW-1:0]         wr_row,
    input  logic [CW-1:0]         wr_column,
    input  logic [3*bitdepth-1:0] wr_data,
    input  logic                  flip_req,
    output logic                  flip_pending,
    output logic                  flip_done,
    output logic                  front,
    output logic                  r,
    output logic                  g,
    output logic                  b
);

    localparam int AW    = 1 + RW + CW;
    localparam int DEPTH = 2 ** AW;
    localparam int PW    = 3 * bitdepth;

    localparam logic [RW:0] ROW_LIMIT = (RW + 1)'(rows);
    localparam logic [CW:0] COL_LIMIT = (CW + 1)'(columns);

    typedef enum logic {
        IDLE,
        PEND
    } flip_state_t;

    flip_state_t state, state_next;
    logic        swap;

    logic [PW-1:0]       mem [DEPTH];
    logic [AW-1:0]       rd_addr;
    logic [PW-1:0]       rd_data;
    logic [bitdepth-1:0] cycle_d;
    logic                wr_ok;

    // Out-of-range coordinates (non-power-of-2 geometry) are dropped rather than aliased.
    assign wr_ok = wr_en
                   && ({1'b0, wr_row} < ROW_LIMIT)
                   && ({1'b0, wr_column} < COL_LIMIT);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[{~front, wr_row, wr_column}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_addr <= '0;
            cycle_d <= '0;
            rd_data <= '0;
            r       <= 1'b0;
            g       <= 1'b0;
            b       <= 1'b0;
        end else begin
            rd_addr <= {front, row, column};
            cycle_d <= cycle;
            rd_data <= mem[rd_addr];
            r       <= rd_data[PW-1 -: bitdepth]         > cycle_d;
            g       <= rd_data[2*bitdepth-1 -: bitdepth] > cycle_d;
            b       <= rd_data[bitdepth-1:0]             > cycle_d;
        end
    end

    // A request is only latched in IDLE, so a same-cycle safe_flip never swaps.
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                if (flip_req) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (safe_flip) begin
                    swap       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            front     <= 1'b0;
            flip_done <= 1'b0;
        end else begin
            state     <= state_next;
            front     <= front ^ swap;
            flip_done <= swap;
        end
    end

    assign flip_pending = (state == PEND);

endmodule

// File: tb/tb_framebuffer_pwm.sv
// Scoreboard bench for framebuffer_pwm: stimulus pushes timed expectations from a
// frame-store reference model; a negedge monitor pops and compares them.
module tb_framebuffer_pwm;

    localparam logic [5:0] ALL   = 6'b111111;
    localparam logic [5:0] FLAGS = 6'b111000;
    localparam logic [5:0] PIX   = 6'b000111;

    logic        clk;
    logic        rst;
    logic [2:0]  row;
    logic [4:0]  column;
    logic [7:0]  cycle;
    logic        safe_flip;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [4:0]  wr_column;
    logic [23:0] wr_data;
    logic        flip_req;
    logic        flip_pending;
    logic        flip_done;
    logic        front;
    logic        r;
    logic        g;
    logic        b;

    framebuffer_pwm #(.rows(8), .columns(32), .bitdepth(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .row          (row),
        .column       (column),
        .cycle        (cycle),
        .safe_flip    (safe_flip),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_column    (wr_column),
        .wr_data      (wr_data),
        .flip_req     (flip_req),
        .flip_pending (flip_pending),
        .flip_done    (flip_done),
        .front        (front),
        .r            (r),
        .g            (g),
        .b            (b)
    );

    typedef struct {
        int         due;
        logic [5:0] val;
        logic [5:0] mask;
        string      name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic        front_m = 1'b0;
    logic [23:0] model_mem [2][8][32];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000 time units");
        $fatal(1, "[TB] timeout");
    end

    // Display rule: a channel bit is set when the channel value is strictly above the PWM cycle.
    function automatic logic [2:0] pwm_ref(input logic [23:0] px, input logic [7:0] c);
        return {px[23:16] > c, px[15:8] > c, px[7:0] > c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int due, input logic [5:0] val, input logic [5:0] mask, input string name);
        exp_t e;
        e.due  = due;
        e.val  = val;
        e.mask = mask;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [2:0] rw, input logic [4:0] cl, input logic [7:0] cy);
        row    = rw;
        column = cl;
        cycle  = cy;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] actual;
        actual = {front, flip_pending, flip_done, r, g, b};
        compared++;
        if ((actual & e.mask) !== (e.val & e.mask)) begin
            mismatched++;
            $display("[TB] FAIL %s @cycle %0d: got {front,pend,done,r,g,b}=%b, required %b (mask %b)",
                     e.name, cyc, actual, e.val, e.mask);
        end
    endtask

    always @(negedge clk) begin
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic write_pixel(input logic [2:0] wr, input logic [4:0] wc, input logic [23:0] d);
        wr_en     = 1'b1;
        wr_row    = wr;
        wr_column = wc;
        wr_data   = d;
        model_mem[front_m ? 0 : 1][wr][wc] = d;
        tick();
    endtask

    task automatic flip_cycle(input string name);
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        push_exp(cyc, {front_m, 1'b1, 1'b0, 3'b000}, FLAGS, {name, "_pend"});
        tick();
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        front_m = ~front_m;
        push_exp(cyc, {front_m, 1'b0, 1'b1, 3'b000}, FLAGS, {name, "_swap"});
        tick();
        push_exp(cyc, {front_m, 1'b0, 1'b0, 3'b000}, FLAGS, {name, "_done_end"});
    endtask

    task automatic read_check(input logic [2:0] rw, input logic [4:0] cl, input logic [7:0] cy, input string name);
        applyStimulus(rw, cl, cy);
        push_exp(cyc + 3, {3'b000, pwm_ref(model_mem[front_m][rw][cl], cy)}, PIX, name);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0; flip_req = 1'b1; safe_flip = 1'b0;
        wr_en = 1'b0; wr_row = '0; wr_column = '0; wr_data = '0;
        applyStimulus(3'd0, 5'd0, 8'd0);

        repeat (3) begin
            tick();
            push_exp(cyc, 6'b000000, ALL, "reset_state");
        end
        rst = 1'b1;
        flip_req = 1'b0;
        tick();
        push_exp(cyc, 6'b000000, FLAGS, "reset_release_idle");

        for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 32; cc++)
                write_pixel(3'(rr), 5'(cc), 24'h000000);
        wr_en = 1'b0;
        flip_cycle("fill_flip");

        // Back bank is filled with full white while the zero front bank is continuously read.
        for (int rr = 0; rr < 8; rr++) begin
            for (int cc = 0; cc < 32; cc++) begin
                applyStimulus(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
                push_exp(cyc + 3, {3'b000, pwm_ref(model_mem[front_m][row][column], 8'd0)}, PIX, "tear_isolation");
                write_pixel(3'(rr), 5'(cc), 24'hFFFFFF);
            end
        end
        wr_en = 1'b0;
        flip_cycle("tear_flip");
        for (int i = 0; i < 12; i++)
            read_check(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 8'd0, "tear_after_flip");
        read_check(3'd1, 5'd1, 8'd255, "white_at_max_cycle");

        flip_req = 1'b1; tick(); flip_req = 1'b0;
        push_exp(cyc, {1'b0, 1'b1, 1'b0, 3'b000}, FLAGS, "hs_pending");
        tick();
        push_exp(cyc, {1'b0, 1'b1, 1'b0, 3'b000}, FLAGS, "hs_pending_gap");
        flip_req = 1'b1; tick(); flip_req = 1'b0;
        push_exp(cyc, {1'b0, 1'b1, 1'b0, 3'b000}, FLAGS, "hs_absorb");
        repeat (10) begin
            tick();
            push_exp(cyc, {1'b0, 1'b1, 1'b0, 3'b000}, FLAGS, "hs_wait");
        end
        safe_flip = 1'b1; tick(); safe_flip = 1'b0;
        front_m = 1'b1;
        push_exp(cyc, {1'b1, 1'b0, 1'b1, 3'b000}, FLAGS, "hs_swap");
        tick();
        push_exp(cyc, {1'b1, 1'b0, 1'b0, 3'b000}, FLAGS, "hs_done_single");
        repeat (3) tick();
        safe_flip = 1'b1; tick(); safe_flip = 1'b0;
        push_exp(cyc, {1'b1, 1'b0, 1'b0, 3'b000}, FLAGS, "hs_no_second_swap");
        tick();
        push_exp(cyc, {1'b1, 1'b0, 1'b0, 3'b000}, FLAGS, "hs_no_second_swap");

        flip_req = 1'b1; safe_flip = 1'b1; tick();
        flip_req = 1'b0; safe_flip = 1'b0;
        push_exp(cyc, {1'b1, 1'b1, 1'b0, 3'b000}, FLAGS, "sim_latch_only");
        tick();
        push_exp(cyc, {1'b1, 1'b1, 1'b0, 3'b000}, FLAGS, "sim_still_pending");
        safe_flip = 1'b1; tick(); safe_flip = 1'b0;
        front_m = 1'b0;
        push_exp(cyc, {1'b0, 1'b0, 1'b1, 3'b000}, FLAGS, "sim_swap");
        tick();
        push_exp(cyc, {1'b0, 1'b0, 1'b0, 3'b000}, FLAGS, "sim_done_end");

        for (int i = 0; i < 40; i++)
            write_pixel(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 24'($urandom()));
        write_pixel(3'd2, 5'd5, 24'h0080FF);
        write_pixel(3'd3, 5'd4, 24'h000000);
        write_pixel(3'd3, 5'd5, 24'hFFFFFF);
        wr_en = 1'b0;
        flip_cycle("pwm_flip");

        applyStimulus(3'd2, 5'd5, 8'd0);
        repeat (4) tick();
        for (int c = 0; c < 256; c++) begin
            cycle = 8'(c);
            push_exp(cyc + 2, {3'b000, pwm_ref(model_mem[front_m][2][5], 8'(c))}, PIX, "pwm_sweep");
            tick();
        end

        applyStimulus(3'd3, 5'd4, 8'd0);
        repeat (4) tick();
        column = 5'd5;
        push_exp(cyc + 1, {3'b000, pwm_ref(model_mem[front_m][3][4], 8'd0)}, PIX, "latency_plus1");
        push_exp(cyc + 2, {3'b000, pwm_ref(model_mem[front_m][3][4], 8'd0)}, PIX, "latency_plus2");
        push_exp(cyc + 3, {3'b000, pwm_ref(model_mem[front_m][3][5], 8'd0)}, PIX, "latency_plus3");
        repeat (5) tick();

        for (int i = 0; i < 60; i++)
            read_check(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), "random_read");

        flip_req = 1'b1; tick(); flip_req = 1'b0;
        push_exp(cyc, {1'b1, 1'b1, 1'b0, 3'b000}, FLAGS, "midpend_pending");
        rst = 1'b0; tick(); rst = 1'b1;
        front_m = 1'b0;
        push_exp(cyc, 6'b000000, ALL, "reset_mid_pend");
        safe_flip = 1'b1; tick(); safe_flip = 1'b0;
        push_exp(cyc, 6'b000000, FLAGS, "reset_drops_request");
        tick();
        push_exp(cyc, 6'b000000, FLAGS, "reset_drops_request");

        repeat (6) tick();
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d unchecked entries, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/framebuffer_pwm.md
Name: framebuffer_pwm

Overview:
- Double-buffered frame store and PWM encoder feeding the display driver's shift outputs.
- Consumes the driver's row/column/cycle/safe_flip and produces per-column R/G/B data bits aligned to the driver's oclk.
- A host-side write port fills the back buffer.
- Host flip requests swap buffers only in the driver's safe_flip window, so frames never tear.

Parameters:
rows, 8, number of addressable rows (must match the driver)
columns, 32, pixels per row (must match the driver)
bitdepth, 8, bits per colour channel (must match the driver)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
row  in  $clog2(rows)  read row address from the driver
column  in  $clog2(columns)  read column address from the driver
cycle  in  bitdepth  PWM cycle count from the driver
safe_flip  in  1  single-cycle flip window from the driver
wr_en  in  1  write strobe; one pixel per cycle
wr_row  in  $clog2(rows)  write row address
wr_column  in  $clog2(columns)  write column address
wr_data  in  3*bitdepth  pixel {R,G,B}; R in the MSBs
flip_req  in  1  host request to swap buffers (pulse)
flip_pending  out  1  request latched, swap not yet taken
flip_done  out  1  one-cycle pulse on the cycle after the swap
front  out  1  index of the bank currently displayed
r  out  1  red data bit to the panel
g  out  1  green data bit to the panel
b  out  1  blue data bit to the panel

Behaviour:
- Reset (rst==0 at a clk edge): front=0, flip_pending=0, flip_done=0, r=g=b=0, pipeline registers cleared. Memory contents are not cleared.
- Storage: 2*rows*columns words of 3*bitdepth bits, inferred as synchronous-read block RAM.
  - Read address = {front, row, column}.
  - Write address = {~front, wr_row, wr_column}.
  - Read and write ports are independent.
  - Reads never see back-bank writes.
- Read pipeline, three stages, matching the driver's timing:
  - S1: register row, column and front into the read address; register cycle into cycle_d.
  - S2: BRAM output valid.
  - S3: r <= (R > cycle_d), g <= (G > cycle_d), b <= (B > cycle_d), registered.
  - Latency: address change to r/g/b is 3 clocks; cycle change to r/g/b is 2 clocks.
- Compare rules:
  - Unsigned, strict greater-than.
  - Channel value 0: bit is never set.
  - Channel value 2^bitdepth-1: bit is set for cycles 0 .. 2^bitdepth-2.
  - cycle wrap-around from max to 0 needs no special handling.
- Writes:
  - A write commits on the clk edge where wr_en=1, to bank ~front as it stood before that edge.
  - A write in the same cycle as a swap lands in the bank that was back before the swap, which is the newly displayed bank. Hosts must not write in the cycle where flip_done would rise.
  - Out-of-range wr_row/wr_column (non-power-of-2 geometry) is ignored, with no write.
- Flip FSM, two states:
  - IDLE: flip_req=1 -> PEND, flip_pending=1.
  - PEND: safe_flip=1 -> front <= ~front, flip_pending <= 0, flip_done <= 1 next cycle, -> IDLE.
  - flip_req in PEND is absorbed: a single swap, no queueing.
  - flip_req and safe_flip both high while in IDLE: the request is latched only and the swap waits for the next safe_flip. A request is never honoured in the same cycle it arrives.
  - safe_flip in IDLE: no effect.
  - flip_done is high for exactly one cycle per swap.
- front changes only at a swap. The driver's safe_flip cycle is followed by its address-load states, so the new bank is used for the whole next frame.
- Reset mid-PEND: the request is dropped and front returns to 0.

Test Plan:
1. Reset behaviour: hold rst=0 for 3 clocks with flip_req=1 -> front=0, flip_pending=0, r=g=b=0.
2. PWM encoding:
   - Stimulus: write pixel (row 2, col 5) = {R=0x00, G=0x80, B=0xFF} to the back bank, flip, then drive row=2, column=5 and sweep cycle 0..255.
   - Expected: r never 1; g=1 for cycle 0..127 only; b=1 for cycle 0..254, 0 at cycle 255.
   - Check the result appears 2 clocks after each cycle change.
3. Latency:
   - Stimulus: hold cycle=0, step column 4->5 where pixel 4 = 0 and pixel 5 = 0xFFFFFF.
   - Expected: r/g/b rise exactly 3 clocks after the column change.
4. Flip handshake:
   - Stimulus: pulse flip_req, pulse flip_req again, then pulse safe_flip 10 clocks later.
   - Expected: flip_pending=1 from the clock after the first request until safe_flip; front toggles 0->1 once; flip_done is a single pulse; no second swap on a later safe_flip.
5. Simultaneous events: flip_req and safe_flip high in the same cycle while IDLE -> no swap; flip_pending=1; swap occurs on the next safe_flip.
6. Tear-free write isolation:
   - Stimulus: fill the front bank with 0x00, then write 0xFFFFFF to all back-bank pixels while sweeping display reads.
   - Expected: r=g=b stay 0 until after flip_done; then all read 1 at cycle=0.
